// File: rtl/cache_line_mover.sv
// Cache miss sequencer. A dirty victim is read from the data array and written back to the bus.
// The missing line is then fetched beat by beat and installed, valid and clean, into the victim way.
module cache_line_mover #(
  parameter int  NUMWAYS = 4,
  parameter int  SETLEN  = 9,
  parameter int  TAGLEN  = 20,
  parameter int  LINELEN = 256,
  parameter int  BEATLEN = 64,
  localparam int BEATS   = LINELEN / BEATLEN,
  localparam int BEAT_W  = $clog2(BEATS)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     MissReq_i,
  input  logic [SETLEN-1:0]        MissSet_i,
  input  logic [TAGLEN-1:0]        MissTag_i,
  input  logic [NUMWAYS-1:0]       VictimWay_i,
  input  logic                     VictimDirty_i,
  input  logic [TAGLEN-1:0]        VictimTag_i,
  output logic                     MissAck_o,
  output logic                     LineReadEn_o,
  input  logic [LINELEN-1:0]       LineRdData_i,
  output logic                     BusReq_o,
  output logic                     BusWrite_o,
  output logic [TAGLEN+SETLEN-1:0] BusAdr_o,
  output logic [BEAT_W-1:0]        BusBeat_o,
  output logic [BEATLEN-1:0]       BusWData_o,
  input  logic [BEATLEN-1:0]       BusRData_i,
  input  logic                     BusReady_i,
  output logic                     LineWriteEn_o,
  output logic [NUMWAYS-1:0]       LineWay_o,
  output logic [SETLEN-1:0]        LineSet_o,
  output logic [LINELEN-1:0]       LineWrData_o,
  output logic [TAGLEN-1:0]        LineTag_o,
  output logic                     SetValid_o,
  output logic                     ClearDirty_o,
  output logic                     FillDone_o
);

  // Bus handshake: BusReq_o is the valid and BusReady_i is the ready signal. A beat transfers on any cycle
  // where both are high. While BusReq_o is high and BusReady_i is low, every bus output holds its value.
  typedef enum logic [2:0] {
    S_IDLE, S_RDVICT, S_CAPT, S_WB, S_GAP, S_FETCH, S_INST
  } state_e;

  state_e                          state_q, state_d;
  logic [BEAT_W-1:0]               cnt_q, cnt_d;
  logic [BEATS-1:0][BEATLEN-1:0]   buf_q, buf_d;
  logic [SETLEN-1:0]               set_q, set_d;
  logic [TAGLEN-1:0]               tag_q, tag_d;
  logic [TAGLEN-1:0]               vtag_q, vtag_d;
  logic [NUMWAYS-1:0]              way_q, way_d;
  logic                            last_beat;

  assign last_beat = (cnt_q == BEAT_W'(BEATS - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    set_d   = set_q;
    tag_d   = tag_q;
    vtag_d  = vtag_q;
    way_d   = way_q;
    unique case (state_q)
      S_IDLE: begin
        if (MissReq_i) begin
          set_d   = MissSet_i;
          tag_d   = MissTag_i;
          vtag_d  = VictimTag_i;
          way_d   = VictimWay_i;
          state_d = VictimDirty_i ? S_RDVICT : S_FETCH;
        end
      end
      S_RDVICT: state_d = S_CAPT;
      S_CAPT: begin
        buf_d   = LineRdData_i;
        state_d = S_WB;
      end
      S_WB: begin
        if (BusReady_i) begin
          cnt_d = cnt_q + 1'b1;
          if (last_beat) state_d = S_GAP;
        end
      end
      S_GAP: state_d = S_FETCH;
      S_FETCH: begin
        if (BusReady_i) begin
          buf_d[cnt_q] = BusRData_i;
          cnt_d        = cnt_q + 1'b1;
          if (last_beat) state_d = S_INST;
        end
      end
      S_INST:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
      set_q   <= '0;
      tag_q   <= '0;
      vtag_q  <= '0;
      way_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      set_q   <= set_d;
      tag_q   <= tag_d;
      vtag_q  <= vtag_d;
      way_q   <= way_d;
    end
  end

  // Every output except MissAck_o is decoded from registered state, so BusReady_i never reaches an output combinationally.
  assign MissAck_o     = (state_q == S_IDLE) && MissReq_i;
  assign LineReadEn_o  = (state_q == S_RDVICT);
  assign BusReq_o      = (state_q == S_WB) || (state_q == S_FETCH);
  assign BusWrite_o    = (state_q == S_WB);
  assign BusAdr_o      = (state_q == S_WB) ? {vtag_q, set_q} : {tag_q, set_q};
  assign BusBeat_o     = cnt_q;
  assign BusWData_o    = buf_q[cnt_q];
  assign LineWriteEn_o = (state_q == S_INST);
  assign SetValid_o    = (state_q == S_INST);
  assign ClearDirty_o  = (state_q == S_INST);
  assign FillDone_o    = (state_q == S_INST);
  assign LineWay_o     = way_q;
  assign LineSet_o     = set_q;
  assign LineTag_o     = tag_q;
  assign LineWrData_o  = buf_q;

endmodule

// File: tb/tb_cache_line_mover.sv
// Bench for cache_line_mover. It applies a table of miss vectors plus hand-written sequences for
// back-to-back requests and a reset in the middle of an operation.
module tb_cache_line_mover;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         MissReq = 1'b0;
  logic [8:0]   MissSet = '0;
  logic [19:0]  MissTag = '0;
  logic [3:0]   VictimWay = '0;
  logic         VictimDirty = 1'b0;
  logic [19:0]  VictimTag = '0;
  logic         MissAck, LineReadEn, BusReq, BusWrite;
  logic [255:0] LineRdData = '0;
  logic [28:0]  BusAdr;
  logic [1:0]   BusBeat;
  logic [63:0]  BusWData;
  logic [63:0]  BusRData = '0;
  logic         BusReady = 1'b0;
  logic         LineWriteEn, SetValid, ClearDirty, FillDone;
  logic [3:0]   LineWay;
  logic [8:0]   LineSet;
  logic [255:0] LineWrData;
  logic [19:0]  LineTag;

  cache_line_mover dut (
    .clk(clk), .reset_n(reset_n),
    .MissReq_i(MissReq), .MissSet_i(MissSet), .MissTag_i(MissTag),
    .VictimWay_i(VictimWay), .VictimDirty_i(VictimDirty), .VictimTag_i(VictimTag),
    .MissAck_o(MissAck), .LineReadEn_o(LineReadEn), .LineRdData_i(LineRdData),
    .BusReq_o(BusReq), .BusWrite_o(BusWrite), .BusAdr_o(BusAdr), .BusBeat_o(BusBeat),
    .BusWData_o(BusWData), .BusRData_i(BusRData), .BusReady_i(BusReady),
    .LineWriteEn_o(LineWriteEn), .LineWay_o(LineWay), .LineSet_o(LineSet),
    .LineWrData_o(LineWrData), .LineTag_o(LineTag), .SetValid_o(SetValid),
    .ClearDirty_o(ClearDirty), .FillDone_o(FillDone)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- vector table ----------------
  typedef struct {
    logic [8:0]   set;
    logic [19:0]  tag;
    logic [3:0]   way;
    logic         dirty;
    logic [19:0]  vtag;
    logic [255:0] rd;
    logic [255:0] fe;
    int           wb_st_beat, wb_st_len, fe_st_beat, fe_st_len;
    int           lat;
  } vec_t;

  vec_t vecs[6];
  vec_t cur_v;

  function automatic vec_t mk(logic [8:0] s, logic [19:0] t, logic [3:0] w, logic d,
                              logic [19:0] vt, logic [255:0] rd, logic [255:0] fe,
                              int wsb, int wsl, int fsb, int fsl, int lat);
    vec_t v;
    v.set = s; v.tag = t; v.way = w; v.dirty = d; v.vtag = vt; v.rd = rd; v.fe = fe;
    v.wb_st_beat = wsb; v.wb_st_len = wsl; v.fe_st_beat = fsb; v.fe_st_len = fsl;
    v.lat = lat;
    return v;
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // ---------------- scoreboard ----------------
  logic [94:0]  wb_q[$];    // {adr, beat, data}
  logic [30:0]  fe_q[$];    // {adr, beat}
  logic [288:0] fill_q[$];  // {way, set, tag, line}
  int           lat_q[$];

  int n_checks = 0;
  int n_fail = 0;

  function automatic void chk(string name, logic [299:0] act, logic [299:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void push_exp(vec_t v);
    if (v.dirty)
      for (int b = 0; b < 4; b++) wb_q.push_back({v.vtag, v.set, 2'(b), v.rd[b*64 +: 64]});
    for (int b = 0; b < 4; b++) fe_q.push_back({v.tag, v.set, 2'(b)});
    fill_q.push_back({v.way, v.set, v.tag, v.fe});
    lat_q.push_back(v.lat);
  endfunction

  // ---------------- monitor / bus model ----------------
  int   cyc = 0, ack_cyc = 0, last_fill_cyc = -100;
  int   ack_cnt = 0, fill_cnt = 0, fe_cnt = 0, wb_left = 0, fe_left = 0;
  bit   mon_en = 0, busy = 0, b2b_mode = 0, b2b_arm = 0, prev_wb_last = 0;
  logic prev_req = 0, prev_rdy = 0, prev_wr = 0;
  logic [28:0] prev_adr;
  logic [1:0]  prev_beat;
  logic [63:0] prev_wdata;

  function automatic void flush_sb();
    wb_q.delete(); fe_q.delete(); fill_q.delete(); lat_q.delete();
    busy = 0; prev_req = 0; prev_wb_last = 0;
  endfunction

  task automatic monitor_cycle();
    logic [94:0]  wexp;
    logic [30:0]  fexp;
    logic [288:0] lexp;
    logic         stall;
    if (prev_req && !prev_rdy)
      chk("stall_hold", {BusReq, BusWrite, BusAdr, BusBeat, BusWData},
          {prev_req, prev_wr, prev_adr, prev_beat, prev_wdata});
    if (MissAck) begin
      chk("ack_not_busy", busy, 1'b0);
      if (b2b_arm) chk("b2b_ack_cycle", cyc, last_fill_cyc + 1);
      if (b2b_mode) b2b_arm = 1;
      busy = 1; ack_cyc = cyc; fe_cnt = 0; ack_cnt++;
      wb_left = cur_v.wb_st_len; fe_left = cur_v.fe_st_len;
    end
    if (LineReadEn) begin
      chk("rdvict_dirty", cur_v.dirty, 1'b1);
      chk("rdvict_cycle", cyc - ack_cyc, 1);
      chk("rdvict_way_set", {LineWay, LineSet}, {cur_v.way, cur_v.set});
    end
    if (prev_wb_last) chk("gap_idle", BusReq, 1'b0);
    prev_wb_last = 0;
    if (BusReq) begin
      stall = 0;
      if (BusWrite && wb_left > 0 && int'(BusBeat) == cur_v.wb_st_beat) begin stall = 1; wb_left--; end
      if (!BusWrite && fe_left > 0 && int'(BusBeat) == cur_v.fe_st_beat) begin stall = 1; fe_left--; end
      BusReady = !stall;
      if (!stall) begin
        if (BusWrite) begin
          if (wb_q.size() == 0) chk("wb_unexpected", {BusAdr, BusBeat, BusWData}, '0);
          else begin
            wexp = wb_q.pop_front();
            chk("wb_beat", {BusAdr, BusBeat, BusWData}, wexp);
            if (wexp[65:64] == 2'd3) prev_wb_last = 1;
          end
        end else begin
          if (fe_q.size() == 0) chk("fetch_unexpected", {BusAdr, BusBeat}, '0);
          else begin
            fexp = fe_q.pop_front();
            chk("fetch_beat", {BusAdr, BusBeat}, fexp);
          end
          if (fe_cnt < 4) BusRData = cur_v.fe[fe_cnt*64 +: 64];
          fe_cnt++;
        end
      end
    end else begin
      BusReady = 1'($urandom_range(0, 1));
    end
    if (LineWriteEn) begin
      if (fill_q.size() == 0) chk("fill_unexpected", {LineWay, LineSet, LineTag, LineWrData}, '0);
      else begin
        lexp = fill_q.pop_front();
        chk("fill_line", {LineWay, LineSet, LineTag, LineWrData}, lexp);
        chk("fill_latency", cyc - ack_cyc, lat_q.pop_front());
      end
      chk("fill_flags", {SetValid, ClearDirty, FillDone}, 3'b111);
      busy = 0; last_fill_cyc = cyc; fill_cnt++;
    end else if (SetValid | ClearDirty | FillDone) begin
      chk("stray_flags", {SetValid, ClearDirty, FillDone}, 3'b000);
    end
    prev_req = BusReq; prev_rdy = BusReady; prev_wr = BusWrite;
    prev_adr = BusAdr; prev_beat = BusBeat; prev_wdata = BusWData;
  endtask

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (mon_en && reset_n) monitor_cycle();
  end

  // ---------------- driver tasks ----------------
  task automatic drive_req(input vec_t v);
    MissSet = v.set; MissTag = v.tag; VictimWay = v.way;
    VictimDirty = v.dirty; VictimTag = v.vtag; LineRdData = v.rd;
    MissReq = 1'b1;
  endtask

  task automatic scramble();
    MissSet = 9'($urandom); MissTag = 20'($urandom); VictimWay = 4'($urandom);
    VictimTag = 20'($urandom); VictimDirty = 1'($urandom);
  endtask

  task automatic wait_fills(input int target);
    for (int t = 0; t < 400; t++) begin
      if (fill_cnt >= target) break;
      @(posedge clk);
    end
    chk("fill_seen", fill_cnt >= target, 1'b1);
    if (fill_cnt < target) flush_sb();
  endtask

  task automatic run_vec(input vec_t v);
    int start;
    start = fill_cnt;
    cur_v = v;
    push_exp(v);
    @(posedge clk); #1;
    drive_req(v);
    @(posedge clk); #1;
    MissReq = 1'b0;
    scramble();
    wait_fills(start + 1);
  endtask

  // ---------------- test ----------------
  initial begin
    int start_ack, start_fill;
    bit found;

    vecs[0] = mk(9'h005, 20'hABCDE, 4'b0100, 1'b0, 20'h0, '0,
                 {{8{8'h44}}, {8{8'h33}}, {8{8'h22}}, {8{8'h11}}}, 0, 0, 0, 0, 5);
    vecs[1] = mk(9'h1A3, 20'h54321, 4'b0001, 1'b1, 20'h12345,
                 {{4{16'hDDDD}}, {4{16'hCCCC}}, {4{16'hBBBB}}, {4{16'hAAAA}}},
                 {{4{16'h5555}}, {4{16'h6666}}, {4{16'h7777}}, {4{16'h8888}}}, 0, 0, 0, 0, 12);
    vecs[2] = mk(9'h0F0, 20'h0BEEF, 4'b0010, 1'b1, 20'hCAFE0, rnd256(), rnd256(), 2, 3, 1, 3, 18);
    vecs[3] = mk(9'h1FF, 20'hFFFFF, 4'b1000, 1'b0, 20'h0, '0, rnd256(), 0, 0, 0, 0, 5);
    vecs[4] = mk(9'($urandom), 20'($urandom), 4'b0001, 1'b1, 20'($urandom),
                 rnd256(), rnd256(), 0, 0, 0, 0, 12);
    vecs[5] = mk(9'h000, 20'h00000, 4'b0110, 1'b0, 20'h0, '0, rnd256(), 0, 0, 3, 2, 7);
    cur_v = vecs[0];

    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    chk("rst_strobes", {MissAck, LineReadEn, BusReq, LineWriteEn, SetValid, ClearDirty, FillDone}, '0);
    chk("rst_latched", {LineWay, LineSet, LineTag}, '0);
    chk("rst_line", LineWrData, '0);
    chk("rst_beat", BusBeat, 2'd0);
    mon_en = 1;

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Back-to-back requests with MissReq held high throughout.
    cur_v = vecs[1];
    push_exp(vecs[1]);
    push_exp(vecs[1]);
    start_ack = ack_cnt;
    start_fill = fill_cnt;
    b2b_mode = 1; b2b_arm = 0;
    @(posedge clk); #1;
    drive_req(vecs[1]);
    for (int t = 0; t < 200; t++) begin
      if (ack_cnt >= start_ack + 2) break;
      @(posedge clk); #1;
    end
    MissReq = 1'b0;
    b2b_mode = 0; b2b_arm = 0;
    chk("b2b_two_acks", ack_cnt - start_ack, 2);
    wait_fills(start_fill + 2);

    // Reset in the middle of the fetch phase.
    cur_v = vecs[0];
    push_exp(vecs[0]);
    @(posedge clk); #1;
    drive_req(vecs[0]);
    @(posedge clk); #1;
    MissReq = 1'b0;
    found = 0;
    for (int t = 0; t < 50; t++) begin
      if (BusReq && !BusWrite && BusBeat == 2'd2) begin found = 1; break; end
      @(posedge clk); #1;
    end
    chk("midop_reached_beat2", found, 1'b1);
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    flush_sb();
    chk("midop_idle", {BusReq, LineWriteEn, FillDone, MissAck}, '0);
    chk("midop_cleared", {LineWay, LineSet, LineTag, LineWrData}, '0);
    repeat (10) @(posedge clk);
    run_vec(vecs[1]);

    repeat (3) @(posedge clk);
    chk("queues_empty", wb_q.size() + fe_q.size() + fill_q.size() + lat_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_line_mover.md
Name: cache_line_mover

Overview:
- Miss-handling datapath sequencer that consumes the victim-way selection (one-hot VictimWay) produced by the replacement logic.
- Dirty victim: reads the line from the data array and writes it back to the bus in beats. Then fetches the missing line beat-by-beat, writes it into the victim way, and marks it valid and clean.
- Sits between the cache controller FSM, the cache tag/data arrays and the bus interface.

Parameters:
- NUMWAYS, 4, number of ways; width of one-hot way selects
- SETLEN, 9, set index width
- TAGLEN, 20, tag width
- LINELEN, 256, line width in bits
- BEATLEN, 64, bus beat width; BEATS = LINELEN/BEATLEN, a power of two, ≥ 2

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- MissReq  in  1  controller requests a line move; sampled only in IDLE
- MissSet  in  SETLEN  set index of the miss
- MissTag  in  TAGLEN  tag of the requested line
- VictimWay  in  NUMWAYS  one-hot victim way
- VictimDirty  in  1  victim line is valid and dirty
- VictimTag  in  TAGLEN  tag currently held by the victim
- MissAck  out  1  one-cycle pulse: request accepted
- LineReadEn  out  1  data-array read strobe; data returns next cycle
- LineRdData  in  LINELEN  data-array read data
- BusReq  out  1  bus transfer active
- BusWrite  out  1  1 = writeback, 0 = fetch
- BusAdr  out  TAGLEN+SETLEN  line address {tag, set}
- BusBeat  out  log2(BEATS)  current beat index
- BusWData  out  BEATLEN  writeback beat data
- BusRData  in  BEATLEN  fetch beat data
- BusReady  in  1  beat completes this cycle
- LineWriteEn  out  1  data/tag array write strobe
- LineWay  out  NUMWAYS  latched way for LineReadEn and LineWriteEn
- LineSet  out  SETLEN  latched set
- LineWrData  out  LINELEN  assembled fill line
- LineTag  out  TAGLEN  tag written (latched MissTag)
- SetValid  out  1  set valid bit (coincident with LineWriteEn)
- ClearDirty  out  1  clear dirty bit (coincident with LineWriteEn)
- FillDone  out  1  one-cycle pulse: line installed

Behaviour:
- Reset (reset_n=0 at a clk edge) → state IDLE, beat counter 0.
  - All strobes and pulses (MissAck, LineReadEn, BusReq, LineWriteEn, SetValid, ClearDirty, FillDone) = 0.
  - Line buffer and latched set/tag/way cleared to 0.
  - Reset mid-operation abandons the transfer with no write to the arrays.
- All outputs are registered-state decodes. No combinational path from BusReady to any output except through state.
- IDLE:
  - MissReq=1 → latch MissSet, MissTag, VictimWay, VictimDirty, VictimTag; MissAck=1 this cycle.
  - Next state: RDVICT if VictimDirty, else FETCH.
  - MissReq=0 → stay.
  - MissReq is ignored in every other state; no MissAck.
- RDVICT (1 cycle): LineReadEn=1 with LineWay/LineSet. → CAPT.
- CAPT (1 cycle): line buffer ← LineRdData. → WB.
- WB:
  - BusReq=1, BusWrite=1, BusAdr={latched VictimTag, set}, BusBeat=cnt, BusWData=buffer[cnt*BEATLEN +: BEATLEN].
  - BusReady=1 → cnt+1; on last beat (cnt=BEATS-1) cnt wraps to 0 and state → GAP.
  - BusReady=0 → hold all outputs.
- GAP (1 cycle): BusReq=0. → FETCH. Guarantees one idle bus cycle between writeback and fetch.
- FETCH:
  - BusReq=1, BusWrite=0, BusAdr={latched MissTag, set}, BusBeat=cnt.
  - BusReady=1 → buffer[cnt*BEATLEN +: BEATLEN] ← BusRData, cnt+1; last beat → cnt=0, state → INST.
- INST (1 cycle): LineWriteEn=SetValid=ClearDirty=FillDone=1, LineWrData=buffer, LineTag=latched MissTag. → IDLE.
- Beat 0 is always the low-order beat; there is no critical-word-first ordering.
- Latency with zero BusReady stalls, from the MissAck cycle to the FillDone cycle:
  - clean: BEATS+1 cycles
  - dirty: 2·BEATS+4 cycles
- Earliest next MissAck: the cycle after FillDone.
- VictimWay is not checked for one-hot; it is latched and forwarded unchanged.

Test Plan:
- Clean miss: MissSet=0x05, MissTag=0xABCDE, VictimWay=0100, VictimDirty=0, BusReady always 1, BusRData beats 0x11..,0x22..,0x33..,0x44.. → MissAck at cycle 0; BusReq/BusWrite=0 cycles 1–4 with BusAdr={0xABCDE,0x05}; cycle 5 LineWriteEn=SetValid=ClearDirty=FillDone=1, LineWay=0100, LineWrData={0x44..,0x33..,0x22..,0x11..}.
- Dirty miss: VictimDirty=1, VictimTag=0x12345, LineRdData=0xDDDD_CCCC_BBBB_AAAA (per-beat patterns) → LineReadEn at cycle 1; WB beats with BusAdr={0x12345,set} emit A,B,C,D in order; one BusReq=0 GAP cycle; then fetch; FillDone at cycle 12.
- Bus stalls: BusReady=0 for 3 cycles during WB beat 2 and FETCH beat 1 → BusBeat/BusWData held stable; beats neither skipped nor duplicated; FillDone delayed by exactly 6 cycles.
- Busy-ignore and back-to-back: MissReq held 1 throughout → second MissAck occurs exactly on the cycle after FillDone; no MissAck while busy.
- Reset mid-op: reset_n=0 for 1 cycle during FETCH beat 2 → next cycle state IDLE, BusReq=0; LineWriteEn never asserts; a new miss then completes normally.
